// File: rtl/video_out_mux_sync.sv
// Frame-synchronous N-source video output selector.
// Each source has a programmable alignment delay line.
// A source change waits for the current frame to end, then blanks the output.
// The output resumes on the new source's aligned vsync rise.
// If the target source stays silent, a timeout forces the switch.
module video_out_mux_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned MAX_DLY    = 7,
  parameter int unsigned DLY_WIDTH  = 3,
  parameter int unsigned TO_WIDTH   = 24
) (
  input  logic                           I_CLK,
  input  logic                           I_RSTN,
  input  logic [SEL_WIDTH-1:0]           i_sel,
  input  logic [NUM_SRC*DLY_WIDTH-1:0]   i_src_dly,
  input  logic [TO_WIDTH-1:0]            i_timeout,
  input  logic [NUM_SRC-1:0]             i_vsync,
  input  logic [NUM_SRC-1:0]             i_hsync,
  input  logic [NUM_SRC-1:0]             i_den,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  i_data,
  output logic                           o_vsync,
  output logic                           o_hsync,
  output logic                           o_den,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [SEL_WIDTH-1:0]           o_cur_sel,
  output logic                           o_busy,
  output logic                           o_sel_err,
  output logic                           o_timeout
);

  // Word layout: {vsync, hsync, den, data}
  localparam int unsigned WordW   = DATA_WIDTH + 3;
  localparam int unsigned NumSlot = 2 ** SEL_WIDTH;

  typedef enum logic [1:0] {StActive, StWaitEof, StBlank} state_e;

  // Slots beyond NUM_SRC read as zero, so any select index is safe to use
  logic [WordW-1:0]   aligned [NumSlot];
  logic [NumSlot-1:0] aligned_v;
  logic [NumSlot-1:0] prev_v_q;
  logic [NumSlot-1:0] rise;

  for (genvar k = 0; k < NumSlot; k++) begin : g_src
    if (k < NUM_SRC) begin : g_used
      logic [WordW-1:0]     stage_q [MAX_DLY];
      logic [WordW-1:0]     raw;
      logic [WordW-1:0]     tap;
      logic [DLY_WIDTH-1:0] dly;

      assign dly = i_src_dly[k*DLY_WIDTH +: DLY_WIDTH];
      assign raw = {i_vsync[k], i_hsync[k], i_den[k], i_data[k*DATA_WIDTH +: DATA_WIDTH]};

      // Delay line shifts every cycle regardless of selection
      always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
          for (int unsigned j = 0; j < MAX_DLY; j++) stage_q[j] <= '0;
        end else begin
          stage_q[0] <= raw;
          for (int unsigned j = 1; j < MAX_DLY; j++) stage_q[j] <= stage_q[j-1];
        end
      end

      // Tap select; oversized delays clamp to the last stage
      always_comb begin
        tap = raw;
        for (int unsigned j = 0; j < MAX_DLY; j++) begin
          if ((32'(dly) == j + 1) || ((j == MAX_DLY - 1) && (32'(dly) > MAX_DLY))) begin
            tap = stage_q[j];
          end
        end
      end

      assign aligned[k] = tap;
    end else begin : g_unused
      assign aligned[k] = '0;
    end
  end

  // Gather aligned vsyncs for edge detection
  always_comb begin
    for (int unsigned k = 0; k < NumSlot; k++) aligned_v[k] = aligned[k][WordW-1];
  end

  assign rise = aligned_v & ~prev_v_q;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  cur_q, cur_d;
  logic [SEL_WIDTH-1:0]  pend_q, pend_d;
  logic [SEL_WIDTH-1:0]  mux_idx, sel_idx;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  sel_err_q, sel_err_d;
  logic                  to_q, to_d;
  logic [WordW-1:0]      out_q, out_d;
  logic                  sel_valid;
  logic                  load_src;
  logic                  use_pend;

  assign sel_valid = (32'(i_sel) < NUM_SRC);

  // Switch sequencing and output-word selection
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    sel_err_d = sel_err_q | ~sel_valid;
    to_d      = to_q;
    load_src  = 1'b1;
    use_pend  = 1'b0;
    unique case (state_q)
      StActive: begin
        if (sel_valid && (i_sel != cur_q)) begin
          pend_d  = i_sel;
          state_d = StWaitEof;
        end
      end
      StWaitEof: begin
        // Returning to the current source beats a same-cycle frame edge
        if (i_sel == cur_q) begin
          state_d = StActive;
        end else begin
          if (sel_valid) pend_d = i_sel;
          if (rise[cur_q]) begin
            state_d  = StBlank;
            cnt_d    = '0;
            load_src = 1'b0;
          end
        end
      end
      StBlank: begin
        load_src = 1'b0;
        if (sel_valid) pend_d = i_sel;
        if (rise[pend_q]) begin
          cur_d    = pend_q;
          state_d  = StActive;
          load_src = 1'b1;
          use_pend = 1'b1;
        end else if (i_timeout != '0) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == i_timeout) begin
            cur_d   = pend_q;
            to_d    = 1'b1;
            state_d = StActive;
          end
        end
      end
      default: state_d = StActive;
    endcase

    mux_idx = use_pend ? pend_q : cur_q;
    sel_idx = (32'(mux_idx) < NUM_SRC) ? mux_idx : '0;
    out_d   = load_src ? aligned[sel_idx] : '0;
  end

  // State, select and output registers
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      state_q   <= StActive;
      cur_q     <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
      to_q      <= 1'b0;
      out_q     <= '0;
      prev_v_q  <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      sel_err_q <= sel_err_d;
      to_q      <= to_d;
      out_q     <= out_d;
      prev_v_q  <= aligned_v;
    end
  end

  assign {o_vsync, o_hsync, o_den, o_data} = out_q;
  assign o_cur_sel = cur_q;
  assign o_busy    = (state_q != StActive);
  assign o_sel_err = sel_err_q;
  assign o_timeout = to_q;

endmodule

// File: tb/tb_video_out_mux_sync.sv
// Directed bench for video_out_mux_sync: latency, clean switch, abort, retarget,
// timeout and invalid select (the latter on a 3-source instance).
module tb_video_out_mux_sync;

  logic        I_CLK;
  logic        I_RSTN;
  logic [1:0]  sel;
  logic [11:0] src_dly;
  logic [23:0] timeout;
  logic [3:0]  vsync, hsync, den;
  logic [31:0] data;

  logic        o_vsync, o_hsync, o_den, o_busy, o_sel_err, o_timeout;
  logic [7:0]  o_data;
  logic [1:0]  o_cur_sel;

  logic [1:0]  sel3;
  logic        o_vsync3, o_hsync3, o_den3, o_busy3, o_sel_err3, o_timeout3;
  logic [7:0]  o_data3;
  logic [1:0]  o_cur_sel3;

  int n_chk  = 0;
  int n_fail = 0;

  video_out_mux_sync u_dut (
    .I_CLK     (I_CLK),
    .I_RSTN    (I_RSTN),
    .i_sel     (sel),
    .i_src_dly (src_dly),
    .i_timeout (timeout),
    .i_vsync   (vsync),
    .i_hsync   (hsync),
    .i_den     (den),
    .i_data    (data),
    .o_vsync   (o_vsync),
    .o_hsync   (o_hsync),
    .o_den     (o_den),
    .o_data    (o_data),
    .o_cur_sel (o_cur_sel),
    .o_busy    (o_busy),
    .o_sel_err (o_sel_err),
    .o_timeout (o_timeout)
  );

  video_out_mux_sync #(.NUM_SRC(3)) u_dut3 (
    .I_CLK     (I_CLK),
    .I_RSTN    (I_RSTN),
    .i_sel     (sel3),
    .i_src_dly (9'd0),
    .i_timeout (24'd0),
    .i_vsync   (vsync[2:0]),
    .i_hsync   (hsync[2:0]),
    .i_den     (den[2:0]),
    .i_data    (data[23:0]),
    .o_vsync   (o_vsync3),
    .o_hsync   (o_hsync3),
    .o_den     (o_den3),
    .o_data    (o_data3),
    .o_cur_sel (o_cur_sel3),
    .o_busy    (o_busy3),
    .o_sel_err (o_sel_err3),
    .o_timeout (o_timeout3)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int k, input logic v, input logic de, input logic [7:0] d);
    vsync[k]       = v;
    den[k]         = de;
    data[k*8 +: 8] = d;
  endtask

  initial begin
    // Reset with random inputs
    I_RSTN  = 1'b0;
    sel     = 2'($urandom);
    sel3    = 2'($urandom);
    src_dly = 12'($urandom);
    timeout = 24'($urandom);
    vsync   = 4'($urandom);
    hsync   = 4'($urandom);
    den     = 4'($urandom);
    data    = $urandom;
    tick();
    tick();
    check("rst_vsync", o_vsync, 0);
    check("rst_hsync", o_hsync, 0);
    check("rst_den", o_den, 0);
    check("rst_data", o_data, 0);
    check("rst_cur_sel", o_cur_sel, 0);
    check("rst_busy", o_busy, 0);
    check("rst_flags", {o_sel_err, o_timeout}, 0);
    check("rst_dut3_out", {o_vsync3, o_den3, o_data3, o_busy3}, 0);

    // src3 dly0, src2 dly5, src1 dly0, src0 dly2
    sel     = 2'd0;
    sel3    = 2'd0;
    src_dly = {3'd0, 3'd5, 3'd0, 3'd2};
    timeout = 24'd0;
    vsync   = '0;
    hsync   = '0;
    den     = '0;
    data    = '0;
    I_RSTN  = 1'b1;
    tick();
    tick();

    // Source 0, dly 2: three-cycle latency
    set_src(0, 1'b0, 1'b1, 8'hA5);
    tick();
    set_src(0, 1'b0, 1'b0, 8'h00);
    tick();
    check("lat0_early", o_data, 0);
    tick();
    check("lat0_data", o_data, 8'hA5);
    check("lat0_den", o_den, 1);
    tick();
    check("lat0_after", o_data, 0);

    // Clean switch 0 -> 2 mid-frame
    set_src(0, 1'b0, 1'b1, 8'h11);
    sel = 2'd2;
    tick();
    check("sw_busy_wait", o_busy, 1);
    check("sw_cur_wait", o_cur_sel, 0);
    tick();
    tick();
    tick();
    check("sw_old_data", o_data, 8'h11);
    set_src(0, 1'b1, 1'b1, 8'h11);
    tick();
    set_src(0, 1'b0, 1'b1, 8'h11);
    tick();
    check("sw_pre_eof_data", o_data, 8'h11);
    check("sw_pre_eof_vs", o_vsync, 0);
    tick();
    check("sw_blank_data", o_data, 0);
    check("sw_blank_vs", o_vsync, 0);
    check("sw_blank_busy", o_busy, 1);
    set_src(0, 1'b0, 1'b0, 8'h00);
    vsync[2] = 1'b1;
    tick();
    vsync[2] = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("sw_new_vs_early", o_vsync, 0);
    check("sw_new_busy_early", o_busy, 1);
    tick();
    check("sw_new_vs", o_vsync, 1);
    check("sw_new_cur", o_cur_sel, 2);
    check("sw_new_busy", o_busy, 0);
    tick();
    check("sw_new_vs_fall", o_vsync, 0);

    // Source 2 alignment: dly 5 gives six-cycle latency
    set_src(2, 1'b0, 1'b1, 8'h5A);
    tick();
    set_src(2, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    check("al2_early", o_data, 0);
    tick();
    check("al2_data", o_data, 8'h5A);
    check("al2_den", o_den, 1);

    // Abort: 2 -> 1 -> 2 before source 2's frame edge
    set_src(2, 1'b0, 1'b1, 8'h77);
    for (int i = 0; i < 6; i++) tick();
    check("ab_pre_data", o_data, 8'h77);
    sel = 2'd1;
    tick();
    check("ab_busy", o_busy, 1);
    check("ab_wait_data", o_data, 8'h77);
    sel = 2'd2;
    tick();
    check("ab_done_busy", o_busy, 0);
    check("ab_done_cur", o_cur_sel, 2);
    check("ab_done_data", o_data, 8'h77);

    // Retarget in blank: 2 -> 1, then 3 while blanking
    sel = 2'd1;
    tick();
    vsync[2] = 1'b1;
    tick();
    vsync[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rt_wait_data", o_data, 8'h77);
    check("rt_wait_busy", o_busy, 1);
    tick();
    check("rt_blank_data", o_data, 0);
    check("rt_blank_busy", o_busy, 1);
    sel = 2'd3;
    tick();
    vsync[1] = 1'b1;
    tick();
    vsync[1] = 1'b0;
    tick();
    check("rt_ignore_src1_busy", o_busy, 1);
    check("rt_ignore_src1_cur", o_cur_sel, 2);
    vsync[3] = 1'b1;
    tick();
    check("rt_land_cur", o_cur_sel, 3);
    check("rt_land_busy", o_busy, 0);
    check("rt_land_vs", o_vsync, 1);
    vsync[3] = 1'b0;
    tick();
    check("rt_land_vs_fall", o_vsync, 0);

    // Timeout: 3 -> 1 with source 1 silent, 100 blank cycles
    set_src(2, 1'b0, 1'b0, 8'h00);
    timeout = 24'd100;
    sel     = 2'd1;
    tick();
    check("to_wait_busy", o_busy, 1);
    vsync[3] = 1'b1;
    tick();
    vsync[3] = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    check("to_still_blank", o_busy, 1);
    check("to_flag_early", o_timeout, 0);
    tick();
    check("to_busy_done", o_busy, 0);
    check("to_flag", o_timeout, 1);
    check("to_cur", o_cur_sel, 1);
    check("to_switch_data", o_data, 0);
    set_src(1, 1'b0, 1'b1, 8'h3C);
    tick();
    check("to_follow_data", o_data, 8'h3C);
    check("to_follow_den", o_den, 1);
    check("main_no_sel_err", o_sel_err, 0);

    // Invalid select on the 3-source instance
    check("inv_pre_err", o_sel_err3, 0);
    sel3 = 2'd3;
    set_src(0, 1'b0, 1'b1, 8'h99);
    tick();
    check("inv_err", o_sel_err3, 1);
    check("inv_busy", o_busy3, 0);
    check("inv_cur", o_cur_sel3, 0);
    check("inv_data", o_data3, 8'h99);
    sel3 = 2'd0;
    tick();
    check("inv_err_sticky", o_sel_err3, 1);
    check("inv_busy_after", o_busy3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_out_mux_sync.md
Name: video_out_mux_sync

Overview:
Parametrised N-source video output selector at the end of the pixel pipeline. It picks one of NUM_SRC sync/den/data streams (bypass, scaler, mirror, blur, ...) and gives each source a runtime-programmable alignment delay. Source changes are frame-synchronous: the old frame finishes, the output is blanked, and the output resumes exactly at the new source's vsync rise. This prevents torn frames downstream. A blanking timeout guards against a dead target source.

Parameters:
DATA_WIDTH, 8, pixel data width per source
NUM_SRC, 4, number of input sources (2..16)
SEL_WIDTH, 2, select width; must satisfy 2^SEL_WIDTH >= NUM_SRC
MAX_DLY, 7, maximum per-source alignment delay in cycles
DLY_WIDTH, 3, per-source delay field width; must hold MAX_DLY
TO_WIDTH, 24, blanking timeout counter width

Ports:
I_CLK  in  1  clock
I_RSTN  in  1  async active-low reset
i_sel  in  SEL_WIDTH  requested source index, level-sensitive
i_src_dly  in  NUM_SRC*DLY_WIDTH  per-source delay; source k uses bits [k*DLY_WIDTH +: DLY_WIDTH]
i_timeout  in  TO_WIDTH  max BLANK cycles before forced switch; 0 = wait forever
i_vsync  in  NUM_SRC  vsync per source, active high
i_hsync  in  NUM_SRC  hsync per source
i_den  in  NUM_SRC  data enable per source
i_data  in  NUM_SRC*DATA_WIDTH  pixel data; source k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
o_vsync  out  1  registered output vsync
o_hsync  out  1  registered output hsync
o_den  out  1  registered output den
o_data  out  DATA_WIDTH  registered output data
o_cur_sel  out  SEL_WIDTH  currently presented source
o_busy  out  1  switch in progress (state != ACTIVE)
o_sel_err  out  1  sticky: i_sel >= NUM_SRC seen; cleared only by reset
o_timeout  out  1  sticky: forced switch on timeout; cleared only by reset

Behaviour:
- Reset is I_RSTN, asynchronous, active-low; clock is I_CLK. All delay stages, edge-detect registers, outputs, o_cur_sel, the pending select, the timeout counter and the sticky flags reset to 0. The state machine resets to ACTIVE.
- Delay line per source:
  - Shift register of MAX_DLY stages holding {v,h,den,data}.
  - Aligned stream k is the tap selected by dly_k: dly 0 = raw input, dly d = input delayed d cycles. Values above MAX_DLY clamp to MAX_DLY.
  - Tap changes take effect the next cycle with no glitch protection. Software changes dly only for unselected sources.
- Output register:
  - ACTIVE or WAIT_EOF (except the rise cycle below): o_* <= aligned[cur_sel].
  - BLANK: o_* <= 0.
  - Total latency from input to output = dly_k + 1 cycles.
- Frame edge: rise_k = aligned_vsync_k & ~prev_aligned_vsync_k. prev is registered every cycle for all sources, whatever the state.
- State machine:
  - ACTIVE: if i_sel < NUM_SRC and i_sel != cur_sel, latch pend <= i_sel and go to WAIT_EOF. If i_sel >= NUM_SRC, set o_sel_err, ignore the request and stay ACTIVE.
  - WAIT_EOF:
    - If i_sel == cur_sel, abort back to ACTIVE with no blank cycle.
    - Otherwise, if i_sel is valid, update pend <= i_sel.
    - On rise_cur: go to BLANK, output register loads 0 in that cycle (the old source's new vsync is suppressed), and clear the timeout counter.
  - BLANK:
    - Output 0. A valid i_sel updates pend; there is no abort.
    - On rise_pend: cur_sel <= pend, go to ACTIVE, and the output register loads aligned[pend] in the same cycle, so o_vsync rises 1 cycle later.
    - Otherwise, if i_timeout != 0, increment the counter. When counter+1 == i_timeout: cur_sel <= pend, set o_timeout, go to ACTIVE, and output aligned[pend] from the next cycle.
- Simultaneous events:
  - rise_cur and a change of i_sel back to cur_sel in the same WAIT_EOF cycle: the abort wins.
  - pend == cur_sel is impossible; that case is handled by the abort.
- The combinational select index never exceeds NUM_SRC-1; invalid indices never reach the mux.
- Reset mid-switch returns to ACTIVE on source 0 with outputs 0.
- Target size is roughly 200-300 lines of RTL using generate loops for delay lines and edge detect.

Test Plan:
- Reset: I_RSTN low with random inputs -> all outputs 0, o_cur_sel=0, o_busy=0; after release, source 0 with dly=2 reaches output 3 cycles after input.
- Alignment: src1 dly=0 and src2 dly=5, each carrying the same pattern offset by 5 cycles -> identical output timing after switching from src1 to src2.
- Clean switch: sel 0->2 mid-frame -> source 0 continues until its next vsync rise; output is 0 from that cycle; o_vsync next rises 1 cycle after src2's aligned vsync rise; o_cur_sel=2, o_busy=0.
- Abort and retarget:
  - sel 0->1, then 0 again before source 0's vsync rise -> no blank cycle, o_busy pulses only while in WAIT_EOF.
  - In BLANK, sel changed 1->3 -> switch lands on 3.
- Timeout: i_timeout=100 and target vsync held low -> exactly 100 BLANK cycles, then o_timeout=1, output follows target.
- Invalid select: NUM_SRC=3, i_sel=3 -> o_sel_err=1, output and o_cur_sel unchanged, o_busy stays 0.
